// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter and issue sequencer for the frame block RAM.
// A streaming writer (auto-incrementing pointer) and a random-access reader
// share one RAM operation per cycle. Contested cycles alternate between them
// using a round-robin token. Read data comes back with a fixed latency of two
// cycles.
module bram_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              wr_clear,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              frame_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addrin,
  output logic [ADDR_W-1:0] ram_addrout,
  output logic [DATA_W-1:0] ram_datain,
  input  logic [DATA_W-1:0] ram_dataout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {TOK_WR, TOK_RD} token_t;

  token_t     token, token_nxt;
  logic       wr_go;
  logic       contested;
  logic       grant_wr, grant_rd;
  logic [1:0] rd_pipe;

  // Round-robin token register; the writer holds priority out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) token <= TOK_WR;
    else      token <= token_nxt;
  end

  // Grant selection; the token only moves after a contested grant.
  // A clear suppresses the write request, so a clear cycle is never contested.
  always_comb begin
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    token_nxt = token;
    wr_go     = wr_valid & ~wr_clear;
    contested = wr_go & rd_req;
    if (contested) begin
      if (token == TOK_WR) begin
        grant_wr  = 1'b1;
        token_nxt = TOK_RD;
      end else begin
        grant_rd  = 1'b1;
        token_nxt = TOK_WR;
      end
    end else begin
      grant_wr = wr_go;
      grant_rd = rd_req;
    end
  end

  // Handshake strobes are held low while reset is asserted.
  always_comb begin
    wr_ready = grant_wr & rst;
    rd_ready = grant_rd & rst;
  end

  // Issue register: the granted operation drives the RAM in the next cycle.
  // Addresses and data hold when nothing is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_wea     <= 1'b0;
      ram_addrin  <= '0;
      ram_addrout <= '0;
      ram_datain  <= '0;
      wr_ptr      <= '0;
      frame_done  <= 1'b0;
    end else begin
      ram_wea    <= 1'b0;
      frame_done <= 1'b0;
      if (wr_clear) begin
        wr_ptr <= '0;
      end
      if (grant_wr) begin
        ram_wea    <= 1'b1;
        ram_addrin <= wr_ptr;
        ram_datain <= wr_data;
        wr_ptr     <= wr_ptr + 1'b1;
        frame_done <= (wr_ptr == LAST_ADDR);
      end else if (grant_rd) begin
        ram_addrout <= rd_addr;
      end
    end
  end

  // Read valid shift: stage 0 marks the address cycle, stage 1 the data cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_pipe <= '0;
    else      rd_pipe <= {rd_pipe[0], grant_rd};
  end

  // Return data only for accepted reads; idle re-reads stay hidden.
  always_comb begin
    rd_rvalid = rd_pipe[1];
    rd_rdata  = rd_pipe[1] ? ram_dataout : '0;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Sequencer and two-requester arbiter for the 16384 x 8 frame block RAM. Accepts a streaming writer (pixel/byte loader, auto-incrementing address) and a random-access reader (processing/display side), grants at most one RAM operation per cycle with round-robin fairness, and drives the RAM's single write-enable / split-address interface. Returns read data with a fixed latency and flags completion of each full-frame load.

## Interface
- ADDR_W, 14, RAM address width; DEPTH = 2^ADDR_W.
- DATA_W, 8, RAM data width.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  writer has a byte.
- wr_data  in  DATA_W  writer byte.
- wr_ready  out  1  write accepted this cycle (handshake = wr_valid & wr_ready).
- wr_clear  in  1  synchronous: reset write pointer to 0.
- wr_ptr  out  ADDR_W  address the next accepted write will use.
- frame_done  out  1  one-cycle pulse: write to address DEPTH-1 issued.
- rd_req  in  1  reader requests a byte.
- rd_addr  in  ADDR_W  read address.
- rd_ready  out  1  read accepted this cycle (handshake = rd_req & rd_ready).
- rd_rvalid  out  1  rd_rdata valid this cycle (no backpressure).
- rd_rdata  out  DATA_W  read data; 0 when rd_rvalid=0.
- ram_wea  out  1  RAM write enable.
- ram_addrin  out  ADDR_W  RAM write address.
- ram_addrout  out  ADDR_W  RAM read address.
- ram_datain  out  DATA_W  RAM write data.
- ram_dataout  in  DATA_W  RAM registered read data (updates only on non-write cycles).

## Operation
- Reset (rst=0): wr_ptr=0, priority token=writer, issue register cleared; all outputs 0 (ram_wea=0, addresses/data 0, rd_rvalid=0, rd_rdata=0, frame_done=0, wr_ready=0, rd_ready=0).
- Arbitration (combinational, cycle N): wr_ready/rd_ready asserted only toward active requesters, never both.
  - Only writer requesting -> grant write; only reader -> grant read.
  - Both -> grant side holding token; token passes to the other side after any contested grant. Uncontested grants leave token unchanged.
  - wr_clear=1 forces wr_ready=0 that cycle (read may still be granted); wr_ptr<=0 at edge.
- Issue register (edge ending N): on write handshake ram_wea<=1, ram_addrin<=wr_ptr, ram_datain<=wr_data, wr_ptr<=wr_ptr+1 (mod DEPTH, DEPTH-1 wraps to 0). On read handshake ram_wea<=0, ram_addrout<=rd_addr. No handshake: ram_wea<=0, addresses/data hold.
- Idle cycles with ram_wea=0 cause a harmless re-read of held ram_addrout; rd_rvalid is not asserted for them.
- frame_done<=1 at the edge issuing the write at wr_ptr=DEPTH-1; else 0.
- Read pipeline: 2-bit valid shift tracks accepted reads; rd_rvalid asserted exactly once per accepted read.
- Ordering: operations reach RAM in handshake order; a read accepted after a write to the same address returns the new data.

## Timing
- Write: handshake cycle N -> RAM control in N+1 -> memory updated at end of N+1.
- Read: handshake cycle N -> ram_addrout in N+1 -> ram_dataout in N+2 -> rd_rvalid=1, rd_rdata=ram_dataout in N+2. Fixed latency 2.
- Throughput: one operation per cycle total; back-to-back reads give rd_rvalid every cycle.
- A write issued in N+2 does not corrupt rd_rdata in N+2 (RAM holds dataout during writes).
- Reset mid-operation: in-flight reads discarded (no rd_rvalid), pending issue dropped, ram_wea forced 0 asynchronously; RAM contents untouched.
- wr_clear together with an otherwise-grantable write: write not accepted, pointer 0, token unchanged.

## Test plan
- Load: wr_valid=1 for 16384 bytes (data=addr[7:0]), no reads -> wr_ready every cycle, frame_done single pulse at issue of addr 16383, wr_ptr wraps to 0.
- Readback: after load, rd_req for addr 0..15 back-to-back -> rd_rvalid continuous from 2 cycles after first handshake, rd_rdata 0x00..0x0F in order.
- Contention: wr_valid=1 and rd_req=1 for 8 cycles from reset -> grants W,R,W,R,W,R,W,R; 4 writes, 4 rd_rvalid.
- RAW: write 0xA5 at wr_ptr=5, read addr 5 next cycle -> rd_rdata=0xA5 two cycles after read handshake.
- wr_clear: after 100 writes assert wr_clear with wr_valid=1 -> wr_ready=0 that cycle, next write lands at addr 0.
- Reset mid-read: issue 2 reads, drop rst next cycle -> no rd_rvalid, all outputs 0, wr_ptr=0, token=writer after release.
